// File: rtl/bus_cycle_gen.sv
// bus_cycle_gen: upstream 8088-style bus master.
// Turns single-beat read/write requests from a valid/ready core interface into
// T1, T2, T3, [TW...], T4 bus cycles with wait states inserted from READY.
//
// Optional feature macro: BUS_WAIT_TIMEOUT_EN
//   defined   - a wait that reaches MAX_WAIT TW cycles is aborted into T4
//               with rsp_err=1 (rsp_rdata left unchanged)
//   undefined - TW persists while READY=0; rsp_err is tied 0
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   req_valid/ready request handshake; req_write, req_io, req_addr, req_wdata
//   rsp_valid       one-cycle completion pulse (in T4)
//   rsp_rdata       read data, held until the next read completes
//   rsp_err         wait timeout flag
//   Address         latched 20-bit bus address
//   ALE             address latch enable (T1 only)
//   RD, WR, CS      active-low read strobe, write strobe, chip select
//   IOM             1 = I/O cycle, 0 = memory cycle
//   ad_out, ad_oe   multiplexed AD bus drive value and output enable
//   ad_in           multiplexed AD bus sampled value
//   READY           target ready; low inserts TW states

module bus_cycle_gen #(
    parameter logic [19:0] CS_BASE  = 20'h00000,
    parameter logic [19:0] CS_MASK  = 20'hE0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] Address,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        CS,
    output logic        IOM,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic [7:0]  ad_in,
    input  logic        READY
);

    localparam int unsigned AW     = 20;
    localparam int unsigned DW     = 8;
    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } state_t;

    // Request fields needed after T1; address and I/O flag live in Address/IOM.
    typedef struct packed {
        logic          write;
        logic [DW-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    req_t              req_q, req_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

    logic          ready_nxt, rsp_valid_nxt, ale_nxt, rd_nxt, wr_nxt, cs_nxt;
    logic          iom_nxt, ad_oe_nxt;
    logic [DW-1:0] rsp_rdata_nxt, ad_out_nxt;
    logic [AW-1:0] addr_nxt, addr_in;
    logic          cs_hit;

`ifdef BUS_WAIT_TIMEOUT_EN
    logic rsp_err_nxt;
`endif

    // I/O cycles only carry a 16-bit port address.
    assign addr_in = req_io ? {4'h0, req_addr[15:0]} : req_addr;
    assign cs_hit  = ~req_io && ((addr_in & CS_MASK) == (CS_BASE & CS_MASK));

    // Next state and next registered output values.
    always_comb begin
        state_nxt     = state;
        req_nxt       = req_q;
        wait_nxt      = wait_cnt;
        ready_nxt     = req_ready;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        ale_nxt       = 1'b0;
        rd_nxt        = RD;
        wr_nxt        = WR;
        cs_nxt        = CS;
        iom_nxt       = IOM;
        addr_nxt      = Address;
        ad_out_nxt    = ad_out;
        ad_oe_nxt     = ad_oe;
`ifdef BUS_WAIT_TIMEOUT_EN
        rsp_err_nxt   = 1'b0;
`endif

        case (state)
            IDLE, T4: begin
                if (req_valid && req_ready) begin
                    state_nxt  = T1;
                    req_nxt    = '{write: req_write, wdata: req_wdata};
                    ready_nxt  = 1'b0;
                    ale_nxt    = 1'b1;
                    rd_nxt     = 1'b1;
                    wr_nxt     = 1'b1;
                    cs_nxt     = ~cs_hit;
                    iom_nxt    = req_io;
                    addr_nxt   = addr_in;
                    ad_out_nxt = addr_in[DW-1:0];
                    ad_oe_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                    cs_nxt    = 1'b1;
                end
            end

            T1: begin
                state_nxt = T2;
                wait_nxt  = '0;
                if (req_q.write) begin
                    wr_nxt     = 1'b0;
                    ad_oe_nxt  = 1'b1;
                    ad_out_nxt = req_q.wdata;
                end else begin
                    rd_nxt    = 1'b0;
                    ad_oe_nxt = 1'b0;
                end
            end

            T2: state_nxt = T3;

            T3, TW: begin
                if (READY) begin
                    state_nxt     = T4;
                    ready_nxt     = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rd_nxt        = 1'b1;
                    wr_nxt        = 1'b1;
                    ad_oe_nxt     = 1'b0;
                    if (!req_q.write) begin
                        rsp_rdata_nxt = ad_in;
                    end
`ifdef BUS_WAIT_TIMEOUT_EN
                end else if (wait_cnt == WAIT_MAX) begin
                    // Abort: finish the cycle without capturing data.
                    state_nxt     = T4;
                    ready_nxt     = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rd_nxt        = 1'b1;
                    wr_nxt        = 1'b1;
                    ad_oe_nxt     = 1'b0;
`endif
                end else begin
                    state_nxt = TW;
                    // Saturating so an endless wait cannot wrap the count.
                    if (wait_cnt != WAIT_MAX) begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_q     <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ALE       <= 1'b0;
            RD        <= 1'b1;
            WR        <= 1'b1;
            CS        <= 1'b1;
            IOM       <= 1'b0;
            Address   <= '0;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_nxt;
            wait_cnt  <= wait_nxt;
            req_ready <= ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            ALE       <= ale_nxt;
            RD        <= rd_nxt;
            WR        <= wr_nxt;
            CS        <= cs_nxt;
            IOM       <= iom_nxt;
            Address   <= addr_nxt;
            ad_out    <= ad_out_nxt;
            ad_oe     <= ad_oe_nxt;
        end
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    // Error flag accompanies the rsp_valid pulse of an aborted cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= rsp_err_nxt;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_gen.sv
// tb_bus_cycle_gen: directed bench for bus_cycle_gen.
// Bus strobe vector used in comparisons: {ALE, RD, WR, CS, IOM, ad_oe}.

module tb_bus_cycle_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [19:0] Address;
    logic        ALE, RD, WR, CS, IOM, ad_oe, READY;
    logic [7:0]  ad_out, ad_in;

    int errors = 0;
    int checks = 0;

    bus_cycle_gen dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Address(Address), .ALE(ALE), .RD(RD), .WR(WR), .CS(CS), .IOM(IOM),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .READY(READY)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; ad_in = '0; READY = 1'b1;
        tick(); tick();
        rst = 1'b1;
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe} !== 6'b011100) begin
            errors++; $display("FAIL reset_bus: got %b expected 011100", {ALE, RD, WR, CS, IOM, ad_oe});
        end
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, Address, ad_out} !== {3'b100, 8'h00, 20'h0, 8'h00}) begin
            errors++; $display("FAIL reset_misc: got rdy=%b rv=%b err=%b rd=%h a=%h ao=%h expected 1 0 0 00 00000 00",
                               req_ready, rsp_valid, rsp_err, rsp_rdata, Address, ad_out);
        end
        tick();
        checks++;
        if ({req_ready, rsp_valid, ALE, RD, WR, CS, ad_oe} !== 7'b1001110) begin
            errors++; $display("FAIL idle_hold: got %b expected 1001110", {req_ready, rsp_valid, ALE, RD, WR, CS, ad_oe});
        end
    endtask

    task automatic test_mem_read();
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h01234;
        ad_in = 8'h00;
        tick(); // cycle 1: T1
        req_valid = 1'b0;
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe, ad_out, Address, req_ready} !== {6'b111001, 8'h34, 20'h01234, 1'b0}) begin
            errors++; $display("FAIL rd_t1: got %b ao=%h a=%h rdy=%b expected 111001 34 01234 0",
                               {ALE, RD, WR, CS, IOM, ad_oe}, ad_out, Address, req_ready);
        end
        tick(); // cycle 2: T2
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe} !== 6'b001000) begin
            errors++; $display("FAIL rd_t2: got %b expected 001000", {ALE, RD, WR, CS, IOM, ad_oe});
        end
        ad_in = 8'hA5;
        tick(); // cycle 3: T3
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe, rsp_valid} !== 7'b0010000) begin
            errors++; $display("FAIL rd_t3: got %b expected 0010000", {ALE, RD, WR, CS, IOM, ad_oe, rsp_valid});
        end
        tick(); // cycle 4: T4
        ad_in = 8'h00;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {2'b10, 8'hA5, 1'b1}) begin
            errors++; $display("FAIL rd_t4_rsp: got rv=%b err=%b data=%h rdy=%b expected 1 0 a5 1",
                               rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe} !== 6'b011000) begin
            errors++; $display("FAIL rd_t4_bus: got %b expected 011000", {ALE, RD, WR, CS, IOM, ad_oe});
        end
        tick(); // cycle 5: IDLE
        checks++;
        if ({rsp_valid, CS, rsp_rdata} !== {2'b01, 8'hA5}) begin
            errors++; $display("FAIL rd_idle: got rv=%b cs=%b data=%h expected 0 1 a5", rsp_valid, CS, rsp_rdata);
        end
    endtask

    task automatic test_io_write();
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1;
        req_addr = 20'hF03F8; req_wdata = 8'h5A;
        tick(); // cycle 1: T1
        req_valid = 1'b0;
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe, ad_out, Address} !== {6'b111111, 8'hF8, 20'h003F8}) begin
            errors++; $display("FAIL wr_t1: got %b ao=%h a=%h expected 111111 f8 003f8",
                               {ALE, RD, WR, CS, IOM, ad_oe}, ad_out, Address);
        end
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if ({ALE, RD, WR, CS, IOM, ad_oe, ad_out} !== {6'b010111, 8'h5A}) begin
                errors++; $display("FAIL wr_strobe c%0d: got %b ao=%h expected 010111 5a",
                                   c, {ALE, RD, WR, CS, IOM, ad_oe}, ad_out);
            end
        end
        tick(); // cycle 4: T4
        checks++;
        if ({rsp_valid, rsp_rdata, ALE, RD, WR, CS, IOM, ad_oe, Address} !== {1'b1, 8'hA5, 6'b011110, 20'h003F8}) begin
            errors++; $display("FAIL wr_t4: got rv=%b data=%h bus=%b a=%h expected 1 a5 011110 003f8",
                               rsp_valid, rsp_rdata, {ALE, RD, WR, CS, IOM, ad_oe}, Address);
        end
        tick();
    endtask

    task automatic test_wait_states();
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00400;
        tick(); // cycle 1
        req_valid = 1'b0;
        tick(); // cycle 2: T2
        READY = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            tick(); // T3 then three TW
            checks++;
            if ({rsp_valid, RD, WR} !== 3'b001) begin
                errors++; $display("FAIL wait c%0d: got rv,rd,wr=%b expected 001", c, {rsp_valid, RD, WR});
            end
        end
        READY = 1'b1; ad_in = 8'h3C;
        tick(); // cycle 7: T4
        ad_in = 8'h00;
        checks++;
        if ({rsp_valid, rsp_err, RD, rsp_rdata} !== {3'b101, 8'h3C}) begin
            errors++; $display("FAIL wait_done: got rv=%b err=%b rd=%b data=%h expected 1 0 1 3c",
                               rsp_valid, rsp_err, RD, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_long_wait();
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00500;
        tick();
        req_valid = 1'b0;
        tick();
        READY = 1'b0; ad_in = 8'hEE;
`ifdef BUS_WAIT_TIMEOUT_EN
        for (int c = 3; c <= 18; c++) begin
            tick();
            checks++;
            if ({rsp_valid, RD} !== 2'b00) begin
                errors++; $display("FAIL tmo_wait c%0d: got rv,rd=%b expected 00", c, {rsp_valid, RD});
            end
        end
        tick(); // cycle 19: aborted T4
        checks++;
        if ({rsp_valid, rsp_err, RD, rsp_rdata} !== {3'b111, 8'h3C}) begin
            errors++; $display("FAIL tmo_abort: got rv=%b err=%b rd=%b data=%h expected 1 1 1 3c",
                               rsp_valid, rsp_err, RD, rsp_rdata);
        end
        READY = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b00) begin
            errors++; $display("FAIL tmo_clear: got rv,err=%b expected 00", {rsp_valid, rsp_err});
        end
`else
        for (int c = 3; c <= 22; c++) begin
            tick();
            checks++;
            if ({rsp_valid, rsp_err, RD} !== 3'b000) begin
                errors++; $display("FAIL long_wait c%0d: got rv,err,rd=%b expected 000", c, {rsp_valid, rsp_err, RD});
            end
        end
        READY = 1'b1; ad_in = 8'h77;
        tick();
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h77}) begin
            errors++; $display("FAIL long_done: got rv=%b err=%b data=%h expected 1 0 77", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
`endif
        ad_in = 8'h00;
    endtask

    task automatic test_cs_boundary();
        logic [19:0] addrs [2];
        logic        cs_exp [2];
        addrs[0] = 20'h1FFFF; cs_exp[0] = 1'b0;
        addrs[1] = 20'h20000; cs_exp[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0;
            req_addr = addrs[i]; req_wdata = 8'hC3;
            tick();
            req_valid = 1'b0;
            checks++;
            if ({CS, Address} !== {cs_exp[i], addrs[i]}) begin
                errors++; $display("FAIL cs_t1 %h: got cs=%b a=%h expected %b", addrs[i], CS, Address, cs_exp[i]);
            end
            tick(); tick(); tick(); // T2, T3, T4
            checks++;
            if ({rsp_valid, CS} !== {1'b1, cs_exp[i]}) begin
                errors++; $display("FAIL cs_t4 %h: got rv=%b cs=%b expected 1 %b", addrs[i], rsp_valid, CS, cs_exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if ({ALE, rsp_valid} !== {(c == 1 || c == 5), (c == 4 || c == 8)}) begin
                errors++; $display("FAIL b2b c%0d: got ale,rv=%b expected %b", c, {ALE, rsp_valid},
                                   {(c == 1 || c == 5), (c == 4 || c == 8)});
            end
            if (c == 4 || c == 8) begin
                checks++;
                if (rsp_rdata !== ((c == 4) ? 8'h11 : 8'h22)) begin
                    errors++; $display("FAIL b2b_data c%0d: got %h expected %h", c, rsp_rdata,
                                       (c == 4) ? 8'h11 : 8'h22);
                end
            end
            if (c == 5) begin
                checks++;
                if (Address !== 20'h00020) begin
                    errors++; $display("FAIL b2b_addr: got %h expected 00020", Address);
                end
            end
            if (c == 1) req_addr = 20'h00020;
            if (c == 3) ad_in = 8'h11;
            if (c == 5) req_valid = 1'b0;
            if (c == 7) ad_in = 8'h22;
        end
        tick();
    endtask

    task automatic test_mid_reset();
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00030;
        ad_in = 8'h44;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 4) begin
                checks++;
                if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h44}) begin
                    errors++; $display("FAIL mr_first: got rv=%b data=%h expected 1 44", rsp_valid, rsp_rdata);
                end
            end
            if (c == 5) req_valid = 1'b0;
        end
        checks++;
        if (RD !== 1'b0) begin
            errors++; $display("FAIL mr_pre: got rd=%b expected 0", RD);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({ALE, RD, WR, CS, IOM, ad_oe, rsp_valid, req_ready} !== 8'b01110001) begin
            errors++; $display("FAIL mr_reset: got %b expected 01110001", {ALE, RD, WR, CS, IOM, ad_oe, rsp_valid, req_ready});
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({rsp_valid, RD} !== 2'b01) begin
                errors++; $display("FAIL mr_after c%0d: got rv,rd=%b expected 01", c, {rsp_valid, RD});
            end
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_states();
        test_long_wait();
        test_cs_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
